// File: rtl/bdd_sram_pkg.sv
// Shared definitions for the SRAM arbiter slice.
// Holds the default SRAM geometry and the controller state encoding.
package bdd_sram_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 32;

  // INIT clears the SRAM after reset; SERVE arbitrates requester traffic.
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

endpackage : bdd_sram_pkg

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant logic.
// Ports:
//   i_valid0 / i_valid1 : requester has a request this cycle
//   i_prio              : requester that wins a tie (0 or 1)
//   o_grant             : one-hot grant, bit N for requester N, zero when idle
module rr_arbiter_2 (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_prio,
  output logic [1:0] o_grant
);

  // Grant the only valid requester, or the favoured one on a tie.
  always_comb begin
    o_grant = 2'b00;
    if (i_valid0 && i_valid1) begin
      o_grant = i_prio ? 2'b10 : 2'b01;
    end else if (i_valid0) begin
      o_grant = 2'b01;
    end else if (i_valid1) begin
      o_grant = 2'b10;
    end else begin
      o_grant = 2'b00;
    end
  end

endmodule : rr_arbiter_2

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM with one-cycle read
// latency. After reset the whole SRAM is cleared to zero, then requests are
// arbitrated round-robin, one per cycle, with a zero-latency command path.
// Ports:
//   i_clk, i_rst_n                   : clock, asynchronous active-low reset
//   i_reqN_valid/write/addr/wdata    : request from requester N
//   o_reqN_ready                     : request N accepted when valid && ready
//   o_rspN_valid/data                : read data for requester N
//   o_sram_addr/write/data           : command to the SRAM
//   i_sram_data                      : SRAM read data (one cycle after address)
//   o_init_done                      : SRAM clear finished
module sram_arbiter
  import bdd_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0_valid,
  input  logic                  i_req1_valid,
  output logic                  o_req0_ready,
  output logic                  o_req1_ready,
  input  logic                  i_req0_write,
  input  logic                  i_req1_write,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_wdata,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  output logic                  o_rsp0_valid,
  output logic                  o_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_rsp0_data,
  output logic [DATA_WIDTH-1:0] o_rsp1_data,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_write,
  output logic [DATA_WIDTH-1:0] o_sram_data,
  input  logic [DATA_WIDTH-1:0] i_sram_data,
  output logic                  o_init_done
);

  state_e                state_r;
  state_e                state_nxt_s;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic                  prio_r;       // requester that wins the next tie
  logic                  init_done_r;
  logic                  rsp0_vld_r;
  logic                  rsp1_vld_r;
  logic [1:0]            grant_s;
  logic                  acc0_s;
  logic                  acc1_s;

  rr_arbiter_2 u_rr (
    .i_valid0 (i_req0_valid),
    .i_valid1 (i_req1_valid),
    .i_prio   (prio_r),
    .o_grant  (grant_s)
  );

  // Next-state decode plus SRAM command mux and request handshakes.
  always_comb begin
    state_nxt_s  = state_r;
    acc0_s       = 1'b0;
    acc1_s       = 1'b0;
    o_sram_write = 1'b0;
    o_sram_addr  = '0;
    o_sram_data  = '0;
    case (state_r)
      ST_INIT: begin
        o_sram_write = 1'b1;
        o_sram_addr  = cnt_r;
        o_sram_data  = '0;
        if (cnt_r == {ADDR_WIDTH{1'b1}}) begin
          state_nxt_s = ST_SERVE;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_SERVE: begin
        acc0_s = grant_s[0];
        acc1_s = grant_s[1];
        if (grant_s[0]) begin
          o_sram_write = i_req0_write;
          o_sram_addr  = i_req0_addr;
          o_sram_data  = i_req0_wdata;
        end else if (grant_s[1]) begin
          o_sram_write = i_req1_write;
          o_sram_addr  = i_req1_addr;
          o_sram_data  = i_req1_wdata;
        end else begin
          o_sram_write = 1'b0;
          o_sram_addr  = '0;
          o_sram_data  = '0;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  assign o_req0_ready = acc0_s;
  assign o_req1_ready = acc1_s;

  // State, clear counter, round-robin priority and pending-response flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_INIT;
      cnt_r       <= '0;
      prio_r      <= 1'b0;
      init_done_r <= 1'b0;
      rsp0_vld_r  <= 1'b0;
      rsp1_vld_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      init_done_r <= init_done_r | (state_nxt_s == ST_SERVE);
      rsp0_vld_r  <= acc0_s & ~i_req0_write;
      rsp1_vld_r  <= acc1_s & ~i_req1_write;
      if (state_r == ST_INIT) begin
        cnt_r <= cnt_r + ADDR_WIDTH'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      // The tie-break favours whoever did not win the latest acceptance.
      if (acc0_s) begin
        prio_r <= 1'b1;
      end else if (acc1_s) begin
        prio_r <= 1'b0;
      end else begin
        prio_r <= prio_r;
      end
    end
  end

  assign o_init_done  = init_done_r;
  assign o_rsp0_valid = rsp0_vld_r;
  assign o_rsp1_valid = rsp1_vld_r;
  assign o_rsp0_data  = rsp0_vld_r ? i_sram_data : '0;
  assign o_rsp1_data  = rsp1_vld_r ? i_sram_data : '0;

endmodule : sram_arbiter

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, SRAM word width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port i_clk  input  1  clock; all state updates on its rising edge.
REQ-005 Port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 Ports i_req0_valid / i_req1_valid  input  1  requester N has a request.
REQ-007 Ports o_req0_ready / o_req1_ready  output  1  request N accepted this cycle when valid&&ready.
REQ-008 Ports i_req0_write / i_req1_write  input  1  1 = write, 0 = read.
REQ-009 Ports i_req0_addr / i_req1_addr  input  ADDR_WIDTH  word address.
REQ-010 Ports i_req0_wdata / i_req1_wdata  input  DATA_WIDTH  write data.
REQ-011 Ports o_rsp0_valid / o_rsp1_valid  output  1  read data for requester N valid this cycle.
REQ-012 Ports o_rsp0_data / o_rsp1_data  output  DATA_WIDTH  read data.
REQ-013 Port o_sram_addr  output  ADDR_WIDTH  to sram i_addr.
REQ-014 Port o_sram_write  output  1  to sram i_write.
REQ-015 Port o_sram_data  output  DATA_WIDTH  to sram i_data.
REQ-016 Port i_sram_data  input  DATA_WIDTH  from sram o_data; valid one cycle after a read address is presented.
REQ-017 Port o_init_done  output  1  SRAM clear complete; requests may be accepted.

Function
REQ-018 FSM states: INIT (clear SRAM), SERVE (arbitrate); no other states.
REQ-019 INIT: counter 0..2^ADDR_WIDTH-1, one per cycle; o_sram_write=1, o_sram_addr=counter, o_sram_data=0.
REQ-020 INIT->SERVE after the write to address 2^ADDR_WIDTH-1; o_init_done=1 from the first SERVE cycle (cycle 16 after reset release for default) and stays 1 until reset.
REQ-021 Both o_reqN_ready SHALL be 0 in INIT.
REQ-022 SERVE: at most one request accepted per cycle; ready driven combinationally, high only for the granted requester, and only while that requester is valid.
REQ-023 One requester valid: it is granted.
REQ-024 Both valid: grant the requester not granted last; round-robin pointer updates to the winner on each acceptance only.
REQ-025 Pointer after reset favours requester 0.
REQ-026 On acceptance, o_sram_addr/o_sram_write/o_sram_data SHALL equal the winner's addr/write/wdata in the same cycle (zero-latency command path).
REQ-027 No acceptance in SERVE: o_sram_write=0, o_sram_addr=0, o_sram_data=0.
REQ-028 Accepted read: o_rspN_valid=1 exactly one cycle after acceptance, for one cycle; o_rspN_data=i_sram_data in that cycle.
REQ-029 Accepted write: no response generated.
REQ-030 Back-to-back reads (either requester) SHALL be sustained at one per cycle; both response valids never high together.
REQ-031 Write then read of same address in consecutive cycles SHALL return the new data.
REQ-032 o_rspN_data SHALL be 0 when o_rspN_valid=0.

Reset
REQ-033 Asserting i_rst_n low SHALL immediately force: state INIT, counter 0, pointer to requester 0, o_init_done=0, both rsp valids 0, both ready 0.
REQ-034 Reset mid-operation SHALL drop any pending response; no o_rspN_valid after reset release until a new read is accepted in SERVE.
REQ-035 After reset release, the full INIT clear SHALL rerun.

Structure
REQ-036 Shared package bdd_sram_pkg SHALL hold ADDR_WIDTH/DATA_WIDTH defaults and the INIT/SERVE state encoding.
REQ-037 Round-robin grant logic SHALL be a sub-module rr_arbiter_2 (inputs: two valids, pointer; outputs: one-hot grant).

Verification
REQ-038 Reset release, no requests -> 16 cycles of writes of 0 to addresses 0..15, ready low throughout, o_init_done=1 on cycle 16.
REQ-039 Req0 writes 0x00020001 to addr 1, next cycle req0 reads addr 1 -> o_rsp0_valid one cycle after read, data 0x00020001.
REQ-040 Req0 and req1 both valid reading addrs 2 and 3 continuously -> grants alternate 0,1,0,1; each rsp one cycle after its grant.
REQ-041 Req1 writes 0x0000BEEF to addr 7 while req0 reads addr 7 in the same cycle -> serialized per pointer; read granted after write returns 0x0000BEEF, else prior value.
REQ-042 Reset asserted the cycle after a read acceptance -> no o_rsp valid, INIT rerun, addr previously written reads back 0.
REQ-043 Requests valid during INIT -> held off (ready 0), accepted on first SERVE cycle, requester 0 first.
